// File: rtl/fractal_sync_node_ctrl.sv
// Barrier-aggregation controller for one fractal sync tree node: arbitrates child requests,
// matches them in a small table, completes locally or forwards up. Optional: FRACTAL_SYNC_NODE_ERR_EN.
module fractal_sync_node_ctrl #(
    parameter int unsigned LVL_WIDTH  = 4,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned NODE_LEVEL = 1,
    parameter int unsigned N_ENTRIES  = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 en_req_valid_i,
    output logic                 en_req_ready_o,
    input  logic [LVL_WIDTH-1:0] en_req_level_i,
    input  logic [ID_WIDTH-1:0]  en_req_id_i,
    input  logic                 ws_req_valid_i,
    output logic                 ws_req_ready_o,
    input  logic [LVL_WIDTH-1:0] ws_req_level_i,
    input  logic [ID_WIDTH-1:0]  ws_req_id_i,
    output logic                 up_req_valid_o,
    input  logic                 up_req_ready_i,
    output logic [LVL_WIDTH-1:0] up_req_level_o,
    output logic [ID_WIDTH-1:0]  up_req_id_o,
    input  logic                 down_rsp_valid_i,
    output logic                 down_rsp_ready_o,
    input  logic [ID_WIDTH-1:0]  down_rsp_id_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [1:0]           rsp_sd_o,
    output logic [ID_WIDTH-1:0]  rsp_id_o,
    output logic                 err_o
);

    localparam int unsigned IdxW = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;
    localparam logic [LVL_WIDTH-1:0] NodeLvl = LVL_WIDTH'(NODE_LEVEL);

    typedef enum logic [1:0] {
        SdNone = 2'b00,
        SdEn   = 2'b01,
        SdWs   = 2'b10,
        SdBoth = 2'b11
    } sd_e;

    // Match table; side 0 = EN, 1 = WS
    logic                 tbl_valid_q [N_ENTRIES];
    logic [LVL_WIDTH-1:0] tbl_lvl_q   [N_ENTRIES];
    logic [ID_WIDTH-1:0]  tbl_id_q    [N_ENTRIES];
    logic                 tbl_side_q  [N_ENTRIES];
    logic                 tbl_valid_d [N_ENTRIES];
    logic [LVL_WIDTH-1:0] tbl_lvl_d   [N_ENTRIES];
    logic [ID_WIDTH-1:0]  tbl_id_d    [N_ENTRIES];
    logic                 tbl_side_d  [N_ENTRIES];

    logic                 ptr_q, ptr_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [1:0]           rsp_sd_q, rsp_sd_d;
    logic [ID_WIDTH-1:0]  rsp_id_q, rsp_id_d;
    logic                 up_valid_q, up_valid_d;
    logic [LVL_WIDTH-1:0] up_lvl_q, up_lvl_d;
    logic [ID_WIDTH-1:0]  up_id_q, up_id_d;

    logic                 sel_ws, req_valid;
    logic [LVL_WIDTH-1:0] req_lvl;
    logic [ID_WIDTH-1:0]  req_id;
    logic                 hit, hit_side, free_found;
    logic [IdxW-1:0]      hit_idx, free_idx;
    logic                 below, is_local, rsp_free, up_free, down_acc;
    logic                 act_drop, act_done, act_alloc, can_commit, req_acc;

    // Arbitration: pointer picks the winner only when both sides are valid
    assign sel_ws    = ws_req_valid_i && (!en_req_valid_i || ptr_q);
    assign req_valid = en_req_valid_i || ws_req_valid_i;
    assign req_lvl   = sel_ws ? ws_req_level_i : en_req_level_i;
    assign req_id    = sel_ws ? ws_req_id_i : en_req_id_i;

    always_comb begin
        hit        = 1'b0;
        hit_idx    = '0;
        hit_side   = 1'b0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int unsigned i = 0; i < N_ENTRIES; i++) begin
            if (!hit && tbl_valid_q[i] && tbl_lvl_q[i] == req_lvl && tbl_id_q[i] == req_id) begin
                hit      = 1'b1;
                hit_idx  = IdxW'(i);
                hit_side = tbl_side_q[i];
            end
            if (!free_found && !tbl_valid_q[i]) begin
                free_found = 1'b1;
                free_idx   = IdxW'(i);
            end
        end
    end

    assign below     = req_lvl < NodeLvl;
    assign is_local  = req_lvl == NodeLvl;
    assign rsp_free  = !rsp_valid_q || rsp_ready_i;
    assign up_free   = !up_valid_q || up_req_ready_i;
    assign down_acc  = down_rsp_valid_i && rsp_free;

    assign act_drop  = below || (hit && hit_side == sel_ws);
    assign act_done  = !below && hit && hit_side != sel_ws;
    assign act_alloc = !below && !hit;

    // A parent response owns the rsp register whenever it is presented
    assign can_commit = act_drop
                     || (act_alloc && free_found)
                     || (act_done && is_local && rsp_free && !down_rsp_valid_i)
                     || (act_done && !is_local && up_free);
    assign req_acc    = req_valid && can_commit;

    assign en_req_ready_o   = en_req_valid_i && !sel_ws && can_commit;
    assign ws_req_ready_o   = sel_ws && can_commit;
    assign down_rsp_ready_o = rsp_free;

    always_comb begin
        for (int unsigned i = 0; i < N_ENTRIES; i++) begin
            tbl_valid_d[i] = tbl_valid_q[i];
            tbl_lvl_d[i]   = tbl_lvl_q[i];
            tbl_id_d[i]    = tbl_id_q[i];
            tbl_side_d[i]  = tbl_side_q[i];
        end
        if (req_acc && act_done) begin
            tbl_valid_d[hit_idx] = 1'b0;
        end
        if (req_acc && act_alloc) begin
            tbl_valid_d[free_idx] = 1'b1;
            tbl_lvl_d[free_idx]   = req_lvl;
            tbl_id_d[free_idx]    = req_id;
            tbl_side_d[free_idx]  = sel_ws;
        end
    end

    always_comb begin
        ptr_d       = req_acc ? !sel_ws : ptr_q;
        rsp_valid_d = rsp_valid_q && !rsp_ready_i;
        rsp_sd_d    = rsp_sd_q;
        rsp_id_d    = rsp_id_q;
        up_valid_d  = up_valid_q && !up_req_ready_i;
        up_lvl_d    = up_lvl_q;
        up_id_d     = up_id_q;
        if (down_acc) begin
            rsp_valid_d = 1'b1;
            rsp_sd_d    = SdBoth;
            rsp_id_d    = down_rsp_id_i;
        end else if (req_acc && act_done && is_local) begin
            rsp_valid_d = 1'b1;
            rsp_sd_d    = SdBoth;
            rsp_id_d    = req_id;
        end
        if (req_acc && act_done && !is_local) begin
            up_valid_d = 1'b1;
            up_lvl_d   = req_lvl;
            up_id_d    = req_id;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < N_ENTRIES; i++) begin
                tbl_valid_q[i] <= 1'b0;
                tbl_lvl_q[i]   <= '0;
                tbl_id_q[i]    <= '0;
                tbl_side_q[i]  <= 1'b0;
            end
            ptr_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_sd_q    <= SdNone;
            rsp_id_q    <= '0;
            up_valid_q  <= 1'b0;
            up_lvl_q    <= '0;
            up_id_q     <= '0;
        end else begin
            for (int unsigned i = 0; i < N_ENTRIES; i++) begin
                tbl_valid_q[i] <= tbl_valid_d[i];
                tbl_lvl_q[i]   <= tbl_lvl_d[i];
                tbl_id_q[i]    <= tbl_id_d[i];
                tbl_side_q[i]  <= tbl_side_d[i];
            end
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_sd_q    <= rsp_sd_d;
            rsp_id_q    <= rsp_id_d;
            up_valid_q  <= up_valid_d;
            up_lvl_q    <= up_lvl_d;
            up_id_q     <= up_id_d;
        end
    end

    assign rsp_valid_o    = rsp_valid_q;
    assign rsp_sd_o       = rsp_sd_q;
    assign rsp_id_o       = rsp_id_q;
    assign up_req_valid_o = up_valid_q;
    assign up_req_level_o = up_lvl_q;
    assign up_req_id_o    = up_id_q;

`ifdef FRACTAL_SYNC_NODE_ERR_EN
    logic err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else begin
            err_q <= req_acc && act_drop;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_fractal_sync_node_ctrl.sv
// Bench for fractal_sync_node_ctrl: vector table plus corner sequences, with a response
// scoreboard fed by the stimulus and drained by a monitor on the output handshakes.
module tb_fractal_sync_node_ctrl;

`ifdef FRACTAL_SYNC_NODE_ERR_EN
    localparam bit ErrEn = 1'b1;
`else
    localparam bit ErrEn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en_valid, en_ready, ws_valid, ws_ready;
    logic [3:0] en_lvl, en_id, ws_lvl, ws_id;
    logic       up_valid, up_ready;
    logic [3:0] up_lvl, up_id;
    logic       dn_valid, dn_ready;
    logic [3:0] dn_id;
    logic       rsp_valid, rsp_ready;
    logic [1:0] rsp_sd;
    logic [3:0] rsp_id;
    logic       err;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [1:0] sd;
        logic [3:0] id;
    } rsp_t;
    typedef struct {
        logic [3:0] lvl;
        logic [3:0] id;
    } up_t;
    // kind: 0 allocate/none, 1 local completion, 2 up completion, 3 error drop
    typedef struct {
        logic       side;
        logic [3:0] lvl;
        logic [3:0] id;
        logic       rdy;
        int         kind;
    } vec_t;

    rsp_t rsp_exp_q[$];
    up_t  up_exp_q[$];
    vec_t vecs[10];

    fractal_sync_node_ctrl #(
        .LVL_WIDTH (4),
        .ID_WIDTH  (4),
        .NODE_LEVEL(1),
        .N_ENTRIES (4)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .en_req_valid_i  (en_valid),
        .en_req_ready_o  (en_ready),
        .en_req_level_i  (en_lvl),
        .en_req_id_i     (en_id),
        .ws_req_valid_i  (ws_valid),
        .ws_req_ready_o  (ws_ready),
        .ws_req_level_i  (ws_lvl),
        .ws_req_id_i     (ws_id),
        .up_req_valid_o  (up_valid),
        .up_req_ready_i  (up_ready),
        .up_req_level_o  (up_lvl),
        .up_req_id_o     (up_id),
        .down_rsp_valid_i(dn_valid),
        .down_rsp_ready_o(dn_ready),
        .down_rsp_id_i   (dn_id),
        .rsp_valid_o     (rsp_valid),
        .rsp_ready_i     (rsp_ready),
        .rsp_sd_o        (rsp_sd),
        .rsp_id_o        (rsp_id),
        .err_o           (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard drain: a handshake seen mid-cycle completes at the next edge
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (rsp_valid && rsp_ready) begin
                if (rsp_exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: got sd=%0b id=%0d expected none", rsp_sd, rsp_id);
                end else begin
                    rsp_t e;
                    e = rsp_exp_q.pop_front();
                    check("rsp_sd", 32'(rsp_sd), 32'(e.sd));
                    check("rsp_id", 32'(rsp_id), 32'(e.id));
                end
            end
            if (up_valid && up_ready) begin
                if (up_exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL up_unexpected: got lvl=%0d id=%0d expected none", up_lvl, up_id);
                end else begin
                    up_t u;
                    u = up_exp_q.pop_front();
                    check("up_lvl", 32'(up_lvl), 32'(u.lvl));
                    check("up_id", 32'(up_id), 32'(u.id));
                end
            end
        end
    end

    task automatic idle_reqs();
        en_valid = 1'b0;
        ws_valid = 1'b0;
    endtask

    task automatic drive_req(input logic side, input logic [3:0] lvl, input logic [3:0] id);
        if (side) begin
            ws_valid = 1'b1;
            ws_lvl   = lvl;
            ws_id    = id;
        end else begin
            en_valid = 1'b1;
            en_lvl   = lvl;
            en_id    = id;
        end
    endtask

    task automatic push_rsp(input logic [3:0] id);
        rsp_t r;
        r.sd = 2'b11;
        r.id = id;
        rsp_exp_q.push_back(r);
    endtask

    task automatic push_up(input logic [3:0] lvl, input logic [3:0] id);
        up_t u;
        u.lvl = lvl;
        u.id  = id;
        up_exp_q.push_back(u);
    endtask

    // One-cycle request accepted unconditionally (used for allocations)
    task automatic send(input logic side, input logic [3:0] lvl, input logic [3:0] id);
        drive_req(side, lvl, id);
        @(negedge clk);
        check("send_ready", 32'(side ? ws_ready : en_ready), 32'd1);
        @(posedge clk);
        #1 idle_reqs();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        logic en_s, ws_s;
        vecs[0] = '{1'b0, 4'd1, 4'd3, 1'b1, 0};
        vecs[1] = '{1'b1, 4'd1, 4'd3, 1'b1, 1};
        vecs[2] = '{1'b0, 4'd2, 4'd5, 1'b1, 0};
        vecs[3] = '{1'b1, 4'd2, 4'd5, 1'b1, 2};
        vecs[4] = '{1'b0, 4'd1, 4'd4, 1'b1, 0};
        vecs[5] = '{1'b0, 4'd1, 4'd4, 1'b1, 3};
        vecs[6] = '{1'b1, 4'd0, 4'd7, 1'b1, 3};
        vecs[7] = '{1'b1, 4'd1, 4'd4, 1'b1, 1};
        vecs[8] = '{1'b1, 4'd3, 4'd9, 1'b1, 0};
        vecs[9] = '{1'b0, 4'd3, 4'd9, 1'b1, 2};

        rst_n = 1'b0;
        en_valid = 1'b0; en_lvl = '0; en_id = '0;
        ws_valid = 1'b0; ws_lvl = '0; ws_id = '0;
        dn_valid = 1'b0; dn_id = '0;
        up_ready = 1'b1; rsp_ready = 1'b1;

        #3;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_up_valid", 32'(up_valid), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rsp_payload", {26'd0, rsp_sd, rsp_id}, 32'd0);
        check("rst_up_payload", {24'd0, up_lvl, up_id}, 32'd0);
        check("rst_dn_ready", 32'(dn_ready), 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Vector table: one request per two cycles, outputs drain freely
        for (int k = 0; k < 10; k++) begin
            drive_req(vecs[k].side, vecs[k].lvl, vecs[k].id);
            @(negedge clk);
            check($sformatf("v%0d_ready", k), 32'(vecs[k].side ? ws_ready : en_ready),
                  32'(vecs[k].rdy));
            check($sformatf("v%0d_err_quiet", k), 32'(err), 32'd0);
            @(posedge clk);
            if (vecs[k].kind == 1) push_rsp(vecs[k].id);
            if (vecs[k].kind == 2) push_up(vecs[k].lvl, vecs[k].id);
            #1 idle_reqs();
            @(negedge clk);
            check($sformatf("v%0d_err", k), 32'(err), 32'(ErrEn && vecs[k].kind == 3));
            check($sformatf("v%0d_rsp_valid", k), 32'(rsp_valid), 32'(vecs[k].kind == 1));
            check($sformatf("v%0d_up_valid", k), 32'(up_valid), 32'(vecs[k].kind == 2));
            @(posedge clk);
            #1;
        end

        // Up register held by parent backpressure; blocks a second up completion
        up_ready = 1'b0;
        send(1'b0, 4'd2, 4'd6);
        drive_req(1'b1, 4'd2, 4'd6);
        @(negedge clk);
        check("hold_ws_ready", 32'(ws_ready), 32'd1);
        @(posedge clk);
        push_up(4'd2, 4'd6);
        #1 idle_reqs();
        send(1'b0, 4'd2, 4'd7);
        drive_req(1'b1, 4'd2, 4'd7);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("hold%0d_up", c), {23'd0, up_valid, up_lvl, up_id},
                  {23'd0, 1'b1, 4'd2, 4'd6});
            check($sformatf("hold%0d_ws_stall", c), 32'(ws_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        up_ready = 1'b1;
        @(negedge clk);
        check("drain_ws_ready", 32'(ws_ready), 32'd1);
        @(posedge clk);
        push_up(4'd2, 4'd7);
        #1 idle_reqs();
        dn_valid = 1'b1;
        dn_id    = 4'd6;
        @(negedge clk);
        check("dn_ready", 32'(dn_ready), 32'd1);
        @(posedge clk);
        push_rsp(4'd6);
        #1 dn_valid = 1'b0;
        @(negedge clk);
        check("dn_rsp_latency", 32'(rsp_valid), 32'd1);
        @(posedge clk);
        #1;

        // Parent response and local completion collide on the rsp register
        send(1'b0, 4'd1, 4'd2);
        dn_valid = 1'b1;
        dn_id    = 4'd1;
        drive_req(1'b1, 4'd1, 4'd2);
        @(negedge clk);
        check("coll_dn_ready", 32'(dn_ready), 32'd1);
        check("coll_ws_stall", 32'(ws_ready), 32'd0);
        @(posedge clk);
        push_rsp(4'd1);
        #1 dn_valid = 1'b0;
        @(negedge clk);
        check("coll_ws_go", 32'(ws_ready), 32'd1);
        @(posedge clk);
        push_rsp(4'd2);
        #1 idle_reqs();
        @(negedge clk);
        check("coll_rsp2_valid", 32'(rsp_valid), 32'd1);
        @(posedge clk);
        #1;

        // Round-robin from a reset pointer until the table fills
        do_reset();
        en_valid = 1'b1; en_lvl = 4'd1; en_id = 4'd0;
        ws_valid = 1'b1; ws_lvl = 4'd1; ws_id = 4'd8;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            en_s = en_ready;
            ws_s = ws_ready;
            check($sformatf("rr%0d_en", c), 32'(en_s), 32'(c < 4 && c % 2 == 0));
            check($sformatf("rr%0d_ws", c), 32'(ws_s), 32'(c < 4 && c % 2 == 1));
            @(posedge clk);
            #1;
            if (en_s) en_id = en_id + 4'd1;
            if (ws_s) ws_id = ws_id + 4'd1;
        end
        idle_reqs();
        drive_req(1'b1, 4'd1, 4'd0);
        @(negedge clk);
        check("full_hit_ready", 32'(ws_ready), 32'd1);
        @(posedge clk);
        push_rsp(4'd0);
        #1 idle_reqs();
        @(negedge clk);
        check("full_hit_rsp", 32'(rsp_valid), 32'd1);
        @(posedge clk);
        #1;
        send(1'b1, 4'd1, 4'd12);

        // Asynchronous reset with pending entries and a stalled response
        do_reset();
        rsp_ready = 1'b0;
        send(1'b0, 4'd1, 4'd10);
        send(1'b0, 4'd2, 4'd11);
        send(1'b0, 4'd1, 4'd12);
        send(1'b1, 4'd1, 4'd12);
        @(negedge clk);
        check("pre_rst_rsp_valid", 32'(rsp_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_rsp", {25'd0, rsp_valid, rsp_sd, rsp_id}, 32'd0);
        check("mid_rst_up", {23'd0, up_valid, up_lvl, up_id}, 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        rsp_ready = 1'b1;
        send(1'b1, 4'd1, 4'd10);
        @(negedge clk);
        check("post_rst_no_complete", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1 drive_req(1'b0, 4'd1, 4'd10);
        @(negedge clk);
        check("post_rst_match_ready", 32'(en_ready), 32'd1);
        @(posedge clk);
        push_rsp(4'd10);
        #1 idle_reqs();
        repeat (3) @(posedge clk);
        #1;

        check("rsp_queue_drained", 32'(rsp_exp_q.size()), 32'd0);
        check("up_queue_drained", 32'(up_exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
